// File: rtl/mips32_pkg.sv
// Shared register-file types and widths for the writeback path.
// The entry struct is the storage format of the MDU pending buffer.
package mips32_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] wa;
        logic [DATA_W-1:0]     wd;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/wb_pend_buf.sv
// Circular buffer of MDU results waiting for the register-file write port.
// Entries can be killed in place by a younger pipeline write to the same register.
module wb_pend_buf
    import mips32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  logic [REG_ADDR_W-1:0]       i_push_wa,
    input  logic [DATA_W-1:0]           i_push_wd,
    input  logic                        i_pop,
    input  logic                        i_kill,
    input  logic [REG_ADDR_W-1:0]       i_kill_wa,
    output logic                        o_head_valid,
    output logic [REG_ADDR_W-1:0]       o_head_wa,
    output logic [DATA_W-1:0]           o_head_wd,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic                        o_empty,
    output logic [NUM_REGS-1:0]         o_pend_mask
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    wb_entry_t         r_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W:0]    r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [NUM_REGS-1:0] w_mask;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // Kill first; pop/push slots never coincide, so later writes win cleanly.
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill && r_mem[i].valid && (r_mem[i].wa == i_kill_wa)) begin
                    r_mem[i].valid <= 1'b0;
                end
            end
            if (w_pop) begin
                r_mem[r_head].valid <= 1'b0;
                r_head              <= r_head + PTR_W'(1);
            end
            if (w_push) begin
                r_mem[r_tail] <= '{valid: 1'b1, wa: i_push_wa, wd: i_push_wd};
                r_tail        <= r_tail + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_mem[i].valid) begin
                w_mask = w_mask | reg_onehot(r_mem[i].wa);
            end
        end
    end

    assign o_pend_mask  = {w_mask[NUM_REGS-1:1], 1'b0};
    assign o_head_valid = r_mem[r_head].valid;
    assign o_head_wa    = r_mem[r_head].wa;
    assign o_head_wd    = r_mem[r_head].wd;
    assign o_count      = r_count;
    assign o_empty      = w_empty;

endmodule

// File: rtl/wb_arbiter.sv
// Owns the register-file write port: pipeline writes always win, MDU results
// bypass straight to the port when idle or wait in the pending buffer.
module wb_arbiter
    import mips32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p_we,
    input  logic [REG_ADDR_W-1:0] p_wa,
    input  logic [DATA_W-1:0]     p_wd,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic [REG_ADDR_W-1:0] m_wa,
    input  logic [DATA_W-1:0]     m_wd,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] wa,
    output logic [DATA_W-1:0]     wd,
    output logic [NUM_REGS-1:0]   pend_mask
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  r_we;
    logic [REG_ADDR_W-1:0] r_wa;
    logic [DATA_W-1:0]     r_wd;

    logic                  w_p_act;
    logic                  w_m_xfer;
    logic                  w_m_drop;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic                  w_head_valid;
    logic [REG_ADDR_W-1:0] w_head_wa;
    logic [DATA_W-1:0]     w_head_wd;

    assign w_p_act  = p_we && (p_wa != '0);
    assign m_ready  = (w_count != CNT_W'(DEPTH));
    assign w_m_xfer = m_valid && m_ready;
    // r0 results are meaningless, and a same-cycle pipeline write to the same register is younger.
    assign w_m_drop = (m_wa == '0) || (w_p_act && (m_wa == p_wa));
    assign w_bypass = w_m_xfer && !w_m_drop && w_empty && !w_p_act;
    assign w_push   = w_m_xfer && !w_m_drop && !w_bypass;
    assign w_pop    = !w_p_act && !w_empty;

    wb_pend_buf #(.DEPTH(DEPTH)) u_pend_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_wa    (m_wa),
        .i_push_wd    (m_wd),
        .i_pop        (w_pop),
        .i_kill       (w_p_act),
        .i_kill_wa    (p_wa),
        .o_head_valid (w_head_valid),
        .o_head_wa    (w_head_wa),
        .o_head_wd    (w_head_wd),
        .o_count      (w_count),
        .o_empty      (w_empty),
        .o_pend_mask  (pend_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we <= 1'b0;
            r_wa <= '0;
            r_wd <= '0;
        end else if (w_p_act) begin
            r_we <= 1'b1;
            r_wa <= p_wa;
            r_wd <= p_wd;
        end else if (w_pop && w_head_valid) begin
            r_we <= 1'b1;
            r_wa <= w_head_wa;
            r_wd <= w_head_wd;
        end else if (w_bypass) begin
            r_we <= 1'b1;
            r_wa <= m_wa;
            r_wd <= m_wd;
        end else begin
            r_we <= 1'b0;
        end
    end

    assign we = r_we;
    assign wa = r_wa;
    assign wd = r_wd;

endmodule
